// File: rtl/fir_sym_mac.sv
// fir_sym_mac: symmetric FIR, one pre-added tap pair MAC per cycle with registered ROM coefficients
module fir_sym_mac #(
  parameter int WIDTH_DATA    = 8,
  parameter int WIDTH_COEF0   = 8,
  parameter int N_TAPS        = 16,
  parameter int WIDTH_MAC_OUT = 8,
  parameter int OUT_SHIFT     = 0
) (
  input  logic                              clk,
  input  logic                              clr,
  input  logic                              in_valid,
  input  logic signed [WIDTH_DATA-1:0]      in_data,
  output logic                              in_ready,
  output logic [$clog2(N_TAPS/2)-1:0]       rom_add,
  input  logic signed [WIDTH_COEF0-1:0]     rom_q,
  output logic                              out_valid,
  output logic signed [WIDTH_MAC_OUT-1:0]   out_data
);
  localparam int H  = N_TAPS / 2;
  localparam int AW = $clog2(H);
  localparam int WP = WIDTH_DATA + 1 + WIDTH_COEF0;
  localparam int WA = WP + AW;
  localparam logic signed [WA-1:0] OMAX = {{(WA-WIDTH_MAC_OUT+1){1'b0}}, {(WIDTH_MAC_OUT-1){1'b1}}};
  localparam logic signed [WA-1:0] OMIN = ~OMAX;
  typedef enum logic [1:0] {IDLE, RUN, LAST, DONE} state_t;
  state_t state, state_nxt;
  logic signed [WIDTH_DATA-1:0] x [N_TAPS];
  logic [AW-1:0] j;
  logic [AW:0] ja, jb;
  logic mac_en, accept, last_k;
  logic signed [WIDTH_DATA:0] pre;
  logic signed [WP-1:0] prod;
  logic signed [WA-1:0] acc, acc_nxt, sh;
  // j is the address presented last cycle, so rom_q now holds its coefficient
  always_comb begin
    in_ready  = state == IDLE;
    out_valid = state == DONE;
    accept    = in_valid && state == IDLE;
    last_k    = rom_add == AW'(H - 1);
    state_nxt = state == IDLE ? (in_valid ? RUN : IDLE)
              : state == RUN  ? (last_k ? LAST : RUN)
              : state == LAST ? DONE : IDLE;
    ja        = {1'b0, j};
    jb        = (AW+1)'(N_TAPS - 1) - ja;
    pre       = (WIDTH_DATA+1)'(x[ja]) + (WIDTH_DATA+1)'(x[jb]);
    prod      = WP'(pre) * WP'(rom_q);
    acc_nxt   = mac_en ? acc + WA'(prod) : acc;
    sh        = acc_nxt >>> OUT_SHIFT;
  end
  always_ff @(posedge clk) begin
    if (clr) begin
      state    <= IDLE;
      x        <= '{default: '0};
      acc      <= '0;
      rom_add  <= '0;
      j        <= '0;
      mac_en   <= 1'b0;
      out_data <= '0;
    end else begin
      state   <= state_nxt;
      mac_en  <= state == RUN;
      j       <= rom_add;
      acc     <= accept ? '0 : acc_nxt;
      rom_add <= (state == RUN && !last_k) ? rom_add + 1'b1 : '0;
      if (accept) begin
        for (int i = N_TAPS - 1; i > 0; i--) x[i] <= x[i-1];
        x[0] <= in_data;
      end
      if (state == LAST)
        out_data <= sh > OMAX ? OMAX[WIDTH_MAC_OUT-1:0]
                  : sh < OMIN ? OMIN[WIDTH_MAC_OUT-1:0] : sh[WIDTH_MAC_OUT-1:0];
    end
  end
endmodule

// File: tb/tb_fir_sym_mac.sv
// tb_fir_sym_mac: table-driven and sequence checks of fir_sym_mac against a direct-form model
module tb_fir_sym_mac;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic clr, in_valid;
  logic signed [7:0] in_data, rom_q, rom_q2, out_data, out_data2;
  logic in_ready, in_ready2, out_valid, out_valid2;
  logic [2:0] rom_add, rom_add2;
  logic signed [7:0] coef [8];
  logic signed [7:0] xm [16];
  logic signed [7:0] q[$], q2[$];
  int n_vec = 0, n_bad = 0, last_out, last_out2;
  typedef struct {
    logic signed [7:0] din;
    logic signed [7:0] exp;
  } vec_t;
  vec_t tbl [17];

  fir_sym_mac dut (.clk(clk), .clr(clr), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .rom_add(rom_add), .rom_q(rom_q), .out_valid(out_valid), .out_data(out_data));
  fir_sym_mac #(.OUT_SHIFT(12)) dut2 (.clk(clk), .clr(clr), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready2), .rom_add(rom_add2), .rom_q(rom_q2), .out_valid(out_valid2), .out_data(out_data2));

  always_ff @(posedge clk) begin
    rom_q  <= coef[rom_add];
    rom_q2 <= coef[rom_add2];
  end

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int model(input int shamt);
    int s = 0;
    for (int k = 0; k < 8; k++) s += (int'(xm[k]) + int'(xm[15-k])) * int'(coef[k]);
    s = s >>> shamt;
    return s > 127 ? 127 : s < -128 ? -128 : s;
  endfunction

  task automatic shift_model(input logic signed [7:0] d);
    for (int i = 15; i > 0; i--) xm[i] = xm[i-1];
    xm[0] = d;
  endtask

  task automatic send(input logic signed [7:0] din, input bit use_exp, input int exp);
    int w = 0;
    while (!in_ready && w < 30) begin @(negedge clk); w++; end
    check("in_ready_wait", int'(in_ready), 1);
    in_valid = 1'b1;
    in_data  = din;
    shift_model(din);
    q.push_back(8'(use_exp ? exp : model(0)));
    q2.push_back(8'(model(12)));
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'(din + 8'sd37);
    w = 1;
    while (!out_valid && w < 20) begin @(negedge clk); w++; end
    check("latency", w, 10);
    if (out_valid) begin
      last_out  = int'(out_data);
      last_out2 = int'(out_data2);
      check("out_data", last_out, int'(q.pop_front()));
      check("out_data_shift12", last_out2, int'(q2.pop_front()));
    end else begin
      q.delete();
      q2.delete();
    end
    @(negedge clk);
    check("out_valid_pulse", int'(out_valid), 0);
  endtask

  initial begin
    int t, na;
    bit rdy, seen;
    for (int k = 0; k < 8; k++) coef[k] = 8'(8 - k);
    for (int i = 0; i < 16; i++) xm[i] = '0;
    for (int i = 0; i < 17; i++) tbl[i] = '{din: (i == 0) ? 8'sd1 : 8'sd0, exp: 8'(i < 8 ? 8 - i : i < 16 ? i - 7 : 0)};
    clr = 1'b1; in_valid = 1'b0; in_data = '0;
    repeat (2) @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_rom_add", int'(rom_add), 0);

    for (int i = 0; i < 17; i++) send(tbl[i].din, 1'b1, int'(tbl[i].exp));

    t = 0; na = 0;
    in_valid = 1'b1;
    for (int c = 0; c < 22; c++) begin
      in_data = 8'($urandom_range(0, 255));
      rdy = in_ready;
      if (rdy) begin
        if (na > 0) check("accept_gap", t, 11);
        shift_model(in_data);
        na++;
        t = 0;
      end
      @(negedge clk);
      t++;
      if (na > 0) begin
        check("timing_rom_add", int'(rom_add), (t >= 1 && t <= 8) ? t - 1 : 0);
        check("timing_out_valid", int'(out_valid), int'(t == 10));
      end
    end
    in_valid = 1'b0;
    check("accept_count", na, 2);

    for (int i = 0; i < 16; i++) send(8'sd127, 1'b0, 0);
    check("sat_pos", last_out, 127);
    for (int i = 0; i < 16; i++) send(-8'sd128, 1'b0, 0);
    check("sat_neg", last_out, -128);

    for (int k = 0; k < 8; k++) coef[k] = -8'sd128;
    send(-8'sd128, 1'b0, 0);
    check("acc_sat_noshift", last_out, 127);
    check("acc_nowrap_shift12", last_out2, 64);

    for (int k = 0; k < 8; k++) coef[k] = 8'(8 - k);
    in_valid = 1'b1; in_data = 8'sd55;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    clr = 1'b1; in_valid = 1'b1; in_data = 8'sd99;
    @(negedge clk);
    clr = 1'b0; in_valid = 1'b0;
    check("clr_in_ready", int'(in_ready), 1);
    check("clr_out_data", int'(out_data), 0);
    seen = 1'b0;
    for (int c = 0; c < 15; c++) begin
      seen |= out_valid;
      @(negedge clk);
    end
    check("clr_no_out_valid", int'(seen), 0);
    for (int i = 0; i < 16; i++) xm[i] = '0;
    send(8'sd1, 1'b1, 8);
    check("post_clr_impulse", last_out, 8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
